// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Two-master round-robin arbiter for the valid/ready memory bus
//            in front of the BRAM controller. Optional GRANT-phase timeout
//            is enabled by defining ARB_TIMEOUT_EN.
// Revision : 1.1 - TIMEOUT_CYCLES always declared
// ============================================================================
module mem_bus_arbiter #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic        grant,
    output logic        busy,
    output logic        bus_err
);

    localparam logic [1:0] C_ST_IDLE    = 2'd0;
    localparam logic [1:0] C_ST_GRANT   = 2'd1;
    localparam logic [1:0] C_ST_RELEASE = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_grant;
    logic       w_grant_next;
    logic       r_busy;
    logic       w_busy_next;
    logic       w_in_grant;
    logic       w_timeout_hit;
    logic       w_done;

    assign w_in_grant = (r_state == C_ST_GRANT);

`ifdef ARB_TIMEOUT_EN
    localparam int C_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_next;
    logic               r_bus_err;
    logic               w_bus_err_next;

    assign w_timeout_hit = w_in_grant && !s_ready && (r_cnt == C_CNT_LAST);
    assign bus_err       = r_bus_err;

    always_comb begin
        w_cnt_next     = '0;
        w_bus_err_next = r_bus_err | w_timeout_hit;
        if (w_in_grant && !s_ready) w_cnt_next = r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_bus_err <= w_bus_err_next;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
    assign bus_err       = 1'b0;
`endif

    assign w_done = w_in_grant && (s_ready || w_timeout_hit);

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        case (r_state)
            C_ST_IDLE: begin
                if (m0_valid && m1_valid) begin
                    w_grant_next = ~r_grant;
                    w_state_next = C_ST_GRANT;
                end else if (m0_valid) begin
                    w_grant_next = 1'b0;
                    w_state_next = C_ST_GRANT;
                end else if (m1_valid) begin
                    w_grant_next = 1'b1;
                    w_state_next = C_ST_GRANT;
                end
            end
            C_ST_GRANT: begin
                if (w_done) w_state_next = C_ST_RELEASE;
            end
            C_ST_RELEASE: w_state_next = C_ST_IDLE;
            default:      w_state_next = C_ST_IDLE;
        endcase
        w_busy_next = (w_state_next != C_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= C_ST_IDLE;
            r_grant <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_busy  <= w_busy_next;
        end
    end

    assign s_valid  = w_in_grant;
    assign s_addr   = r_grant ? m1_addr  : m0_addr;
    assign s_wdata  = r_grant ? m1_wdata : m0_wdata;
    assign s_wstrb  = w_in_grant ? (r_grant ? m1_wstrb : m0_wstrb) : 4'b0000;

    assign m0_ready = w_done && !r_grant;
    assign m1_ready = w_done && r_grant;
    assign m0_rdata = w_timeout_hit ? ERR_RDATA : s_rdata;
    assign m1_rdata = w_timeout_hit ? ERR_RDATA : s_rdata;

    assign grant    = r_grant;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed self-checking bench for mem_bus_arbiter.
// Revision : 1.1 - unconditional parameter override
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        grant, busy, bus_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_rdy0   = 0;
    int n_rdy1   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .grant(grant), .busy(busy), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready  = 1'b0; s_rdata = '0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_grant",   32'(grant),   32'd1);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_m_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        tick();
        reset = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        chk("idle_s_valid", 32'(s_valid), 32'd0);
        chk("idle_busy",    32'(busy),    32'd0);
        tick();
    endtask

    task automatic arb_grant(input logic exp_g, input int lat, input logic [31:0] rd,
                             input logic [31:0] ea, input logic [31:0] ewd,
                             input logic [3:0] ews, input logic drop);
        for (int i = 0; i < lat; i++) begin
            s_ready = (i == lat - 1);
            s_rdata = rd;
            @(negedge clk);
            chk("g_s_valid", 32'(s_valid), 32'd1);
            chk("g_grant",   32'(grant),   32'(exp_g));
            if (i == 0) begin
                chk("g_s_addr",  s_addr,  ea);
                chk("g_s_wdata", s_wdata, ewd);
                chk("g_s_wstrb", 32'(s_wstrb), 32'(ews));
            end
            if (m0_ready) n_rdy0++;
            if (m1_ready) n_rdy1++;
            if (i == lat - 1) begin
                chk("g_m0_ready", 32'(m0_ready), 32'(!exp_g));
                chk("g_m1_ready", 32'(m1_ready), 32'(exp_g));
                chk("g_rdata", exp_g ? m1_rdata : m0_rdata, rd);
            end else begin
                chk("g_no_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
            end
            tick();
        end
        s_ready = 1'b0;
        if (drop) begin
            if (exp_g) m1_valid = 1'b0;
            else       m0_valid = 1'b0;
        end
        @(negedge clk);
        chk("rel_s_valid", 32'(s_valid), 32'd0);
        chk("rel_busy",    32'(busy),    32'd1);
        chk("rel_s_wstrb", 32'(s_wstrb), 32'd0);
        chk("rel_ready",   {30'd0, m1_ready, m0_ready}, 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply_reset();
        m0_valid = 1'b1; m0_addr = 32'h0; m0_wstrb = 4'b0000;
        idle_cycle();
        arb_grant(1'b0, 3, 32'h09900093, 32'h0, 32'h0, 4'b0000, 1'b1);
        @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_grant",     32'(grant), 32'd0);
        tick();

        apply_reset();
        m0_valid = 1'b1; m0_addr = 32'h80; m0_wdata = 32'h12345678; m0_wstrb = 4'b1111;
        m1_valid = 1'b1; m1_addr = 32'h84; m1_wdata = 32'h0;        m1_wstrb = 4'b0000;
        idle_cycle();
        arb_grant(1'b0, 1, 32'h0, 32'h80, 32'h12345678, 4'b1111, 1'b1);
        idle_cycle();
        arb_grant(1'b1, 2, 32'hCAFE0001, 32'h84, 32'h0, 4'b0000, 1'b1);

        apply_reset();
        n_rdy0 = 0; n_rdy1 = 0;
        m0_valid = 1'b1; m0_addr = 32'h100; m0_wdata = 32'hA0; m0_wstrb = 4'b0011;
        m1_valid = 1'b1; m1_addr = 32'h200; m1_wdata = 32'hB0; m1_wstrb = 4'b1100;
        for (int k = 0; k < 6; k++) begin
            idle_cycle();
            if (k % 2 == 0)
                arb_grant(1'b0, 1, 32'h1000 + 32'(k), 32'h100, 32'hA0, 4'b0011, 1'b0);
            else
                arb_grant(1'b1, 1, 32'h1000 + 32'(k), 32'h200, 32'hB0, 4'b1100, 1'b0);
        end
        chk("rr_m0_pulses", 32'(n_rdy0), 32'd3);
        chk("rr_m1_pulses", 32'(n_rdy1), 32'd3);

        apply_reset();
        m1_valid = 1'b1; m1_addr = 32'h300; m1_wdata = 32'h77; m1_wstrb = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            idle_cycle();
            arb_grant(1'b1, 2, 32'h2000 + 32'(k), 32'h300, 32'h77, 4'b1111, 1'b0);
        end
        m1_valid = 1'b0;
        @(negedge clk);
        chk("m1only_grant", 32'(grant), 32'd1);
        tick();

        apply_reset();
        m0_valid = 1'b1; m0_addr = 32'h40;
        idle_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("rstg_s_valid", 32'(s_valid), 32'd1);
        chk("rstg_ready",   {30'd0, m1_ready, m0_ready}, 32'd0);
        tick();
        reset = 1'b0;
        m1_valid = 1'b1; m1_addr = 32'h44;
        @(negedge clk);
        chk("rstg_busy",     32'(busy),    32'd0);
        chk("rstg_s_valid2", 32'(s_valid), 32'd0);
        chk("rstg_grant",    32'(grant),   32'd1);
        tick();
        arb_grant(1'b0, 1, 32'h3333, 32'h40, 32'h0, 4'b0000, 1'b1);
        m1_valid = 1'b0;
        tick();

`ifdef ARB_TIMEOUT_EN
        apply_reset();
        m0_valid = 1'b1; m0_addr = 32'h500;
        s_rdata  = 32'h11111111;
        idle_cycle();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("to_s_valid", 32'(s_valid), 32'd1);
            chk("to_m0_ready", 32'(m0_ready), 32'(i == 8));
            if (i == 8) chk("to_rdata", m0_rdata, 32'hDEADBEEF);
            chk("to_bus_err", 32'(bus_err), 32'd0);
            tick();
        end
        m0_valid = 1'b0;
        s_ready  = 1'b1;
        @(negedge clk);
        chk("to_rel_s_valid", 32'(s_valid), 32'd0);
        chk("to_late_ready",  {30'd0, m1_ready, m0_ready}, 32'd0);
        chk("to_bus_err_set", 32'(bus_err), 32'd1);
        tick();
        s_ready  = 1'b0;
        m1_valid = 1'b1; m1_addr = 32'h600; m1_wdata = 32'h5A; m1_wstrb = 4'b1111;
        idle_cycle();
        arb_grant(1'b1, 2, 32'h00000055, 32'h600, 32'h5A, 4'b1111, 1'b1);
        @(negedge clk);
        chk("to_bus_err_held", 32'(bus_err), 32'd1);
        tick();
`else
        @(negedge clk);
        chk("no_to_bus_err", 32'(bus_err), 32'd0);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
